// File: rtl/imem_loader_pkg.sv
// imem_loader_pkg
// Shared definitions for the instruction-memory boot loader:
//   state_t        - loader session states
//   BYTES_PER_WORD - stream bytes packed into one instruction word
//   HDR_BYTES      - length-header bytes at the start of a frame
//   word_addr()    - converts a word index into a byte address
package imem_loader_pkg;

    localparam int BYTES_PER_WORD = 4;
    localparam int HDR_BYTES      = 2;

    typedef enum logic [2:0] {
        IDLE,
        LEN_LO,
        LEN_HI,
        DATA,
        CHK,
        DONE,
        ERR
    } state_t;

    function automatic logic [31:0] word_addr(input logic [31:0] idx);
        return 32'(idx * BYTES_PER_WORD);
    endfunction

endpackage

// File: rtl/imem_loader_if.sv
// imem_loader_if
// Bundles the byte-stream handshake and the instruction-memory write port.
//   byte_valid_i / byte_data_i / byte_ready_o : host byte link
//   imem_we_o / imem_waddr_o / imem_wdata_o   : instruction memory write port
// Signal suffixes are from the loader's point of view.
//   master : host / memory side (drives the byte stream)
//   slave  : the loader itself
interface imem_loader_if;

    logic        byte_valid_i;
    logic [7:0]  byte_data_i;
    logic        byte_ready_o;
    logic        imem_we_o;
    logic [31:0] imem_waddr_o;
    logic [31:0] imem_wdata_o;

    modport master (
        output byte_valid_i,
        output byte_data_i,
        input  byte_ready_o,
        input  imem_we_o,
        input  imem_waddr_o,
        input  imem_wdata_o
    );

    modport slave (
        input  byte_valid_i,
        input  byte_data_i,
        output byte_ready_o,
        output imem_we_o,
        output imem_waddr_o,
        output imem_wdata_o
    );

endinterface

// File: rtl/imem_loader_word_assembler.sv
// word_assembler
// Packs accepted data bytes little-endian into 32-bit words and keeps the
// running XOR checksum of the frame.
//   clk_i        : clock
//   rst_i        : asynchronous active-low reset
//   clr_i        : synchronous clear at the start of a session
//   byte_acc_i   : a data byte is accepted this cycle
//   xor_en_i     : fold byte_data_i into the checksum this cycle
//   byte_data_i  : stream byte
//   word_o       : assembled word, valid while word_done_o is high
//   word_done_o  : the 4th byte of a word is being accepted this cycle
//   chk_xor_o    : running XOR of all folded bytes
module word_assembler (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        clr_i,
    input  logic        byte_acc_i,
    input  logic        xor_en_i,
    input  logic [7:0]  byte_data_i,
    output logic [31:0] word_o,
    output logic        word_done_o,
    output logic [7:0]  chk_xor_o
);

    logic [1:0]  cnt_q;
    logic [23:0] lanes_q;
    logic [7:0]  xor_q;

    // Byte lane counter, lower three lanes and checksum. The top lane is never
    // stored: it is the byte on the input when the word completes.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            cnt_q   <= 2'd0;
            lanes_q <= 24'd0;
            xor_q   <= 8'd0;
        end else if (clr_i) begin
            cnt_q   <= 2'd0;
            lanes_q <= 24'd0;
            xor_q   <= 8'd0;
        end else begin
            if (byte_acc_i) begin
                cnt_q <= cnt_q + 2'd1;
                case (cnt_q)
                    2'd0:    lanes_q[7:0]   <= byte_data_i;
                    2'd1:    lanes_q[15:8]  <= byte_data_i;
                    2'd2:    lanes_q[23:16] <= byte_data_i;
                    default: ;
                endcase
            end
            if (xor_en_i) begin
                xor_q <= xor_q ^ byte_data_i;
            end
        end
    end

    assign word_o      = {byte_data_i, lanes_q};
    assign word_done_o = byte_acc_i && (cnt_q == 2'd3);
    assign chk_xor_o   = xor_q;

endmodule

// File: rtl/imem_loader.sv
// imem_loader
// Boot-time writer for the CPU instruction memory. Receives a frame
// (LEN_LO, LEN_HI, 4*N data bytes, CHK) over a valid/ready byte link, writes
// one 32-bit word per 4 data bytes and releases the CPU after a clean load.
//   clk_i      : clock
//   rst_i      : asynchronous active-low reset
//   load_req_i : one-cycle request to start a session (IDLE/DONE/ERR only)
//   bus        : byte link and instruction-memory write port (slave side)
//   start_o    : CPU start, high while in DONE
//   busy_o     : session in progress
//   done_o     : last session succeeded
//   err_o      : last session failed
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int DEPTH = 256,
    parameter int LEN_W = 16
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          load_req_i,
    imem_loader_if.slave  bus,
    output logic          start_o,
    output logic          busy_o,
    output logic          done_o,
    output logic          err_o
);

    state_t state_q, state_d;

    logic [7:0]       len_lo_q;
    logic [LEN_W-1:0] len_q;
    logic [LEN_W-1:0] idx_q;
    logic             we_q;
    logic [31:0]      waddr_q;
    logic [31:0]      wdata_q;

    logic             byte_ready;
    logic             accept;
    logic             load_go;
    logic [LEN_W-1:0] hdr_len;
    logic             last_word;
    logic [31:0]      word;
    logic             word_done;
    logic [7:0]       chk_xor;

    assign accept    = bus.byte_valid_i && byte_ready;
    assign load_go   = load_req_i && (state_q == IDLE || state_q == DONE || state_q == ERR);
    assign hdr_len   = LEN_W'({bus.byte_data_i, len_lo_q});
    assign last_word = (idx_q == len_q - LEN_W'(1));

    word_assembler u_asm (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .clr_i       (load_go),
        .byte_acc_i  (accept && state_q == DATA),
        .xor_en_i    (accept && (state_q == LEN_LO || state_q == LEN_HI || state_q == DATA)),
        .byte_data_i (bus.byte_data_i),
        .word_o      (word),
        .word_done_o (word_done),
        .chk_xor_o   (chk_xor)
    );

    // State register
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; the length check uses the header byte on the bus so
    // an oversize frame is rejected on the LEN_HI accept itself.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, DONE, ERR: begin
                if (load_req_i) state_d = LEN_LO;
            end
            LEN_LO: begin
                if (accept) state_d = LEN_HI;
            end
            LEN_HI: begin
                if (accept) begin
                    if (32'(hdr_len) > 32'(DEPTH)) state_d = ERR;
                    else if (hdr_len == '0)        state_d = CHK;
                    else                           state_d = DATA;
                end
            end
            DATA: begin
                if (word_done && last_word) state_d = CHK;
            end
            CHK: begin
                if (accept) state_d = (bus.byte_data_i == chk_xor) ? DONE : ERR;
            end
            default: state_d = IDLE;
        endcase
    end

    // Status outputs are pure state decodes, so done/err stay sticky until a
    // new session leaves DONE/ERR.
    always_comb begin
        byte_ready = 1'b0;
        busy_o     = 1'b0;
        start_o    = 1'b0;
        done_o     = 1'b0;
        err_o      = 1'b0;
        case (state_q)
            LEN_LO, LEN_HI, DATA, CHK: begin
                byte_ready = 1'b1;
                busy_o     = 1'b1;
            end
            DONE: begin
                start_o = 1'b1;
                done_o  = 1'b1;
            end
            ERR: begin
                err_o = 1'b1;
            end
            default: ;
        endcase
    end

    // Header latches, word index and the registered write port. Address and
    // data hold between write pulses.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            len_lo_q <= 8'd0;
            len_q    <= '0;
            idx_q    <= '0;
            we_q     <= 1'b0;
            waddr_q  <= 32'd0;
            wdata_q  <= 32'd0;
        end else begin
            we_q <= word_done;
            if (load_go) begin
                len_lo_q <= 8'd0;
                len_q    <= '0;
                idx_q    <= '0;
            end else begin
                if (accept && state_q == LEN_LO) len_lo_q <= bus.byte_data_i;
                if (accept && state_q == LEN_HI) len_q    <= hdr_len;
                if (word_done) begin
                    waddr_q <= word_addr(32'(idx_q));
                    wdata_q <= word;
                    idx_q   <= idx_q + LEN_W'(1);
                end
            end
        end
    end

    assign bus.byte_ready_o = byte_ready;
    assign bus.imem_we_o    = we_q;
    assign bus.imem_waddr_o = waddr_q;
    assign bus.imem_wdata_o = wdata_q;

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader
// Scoreboard bench for imem_loader: directed frames push their hand-computed
// writes into a queue, a monitor pops and checks every imem_we_o pulse
// (address, data and cycle), status outputs are checked after each frame.
module tb_imem_loader;

    typedef logic [7:0] byte_q_t[$];
    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    logic clk = 1'b0;
    logic rst_i = 1'b0;
    logic load_req_i = 1'b0;
    logic start_o, busy_o, done_o, err_o;

    imem_loader_if bus ();

    imem_loader #(.DEPTH(256), .LEN_W(16)) dut (
        .clk_i      (clk),
        .rst_i      (rst_i),
        .load_req_i (load_req_i),
        .bus        (bus),
        .start_o    (start_o),
        .busy_o     (busy_o),
        .done_o     (done_o),
        .err_o      (err_o)
    );

    int    passed = 0;
    int    total  = 0;
    int    cyc    = 0;
    wr_t   exp_q[$];
    int    lat_q[$];
    byte_q_t f;

    always #5 clk = ~clk;

    // Cycle counter used to check write latency
    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("[TB] FAIL %s: got %h expected %h", name, got, exp);
    endtask

    task automatic checkStatus(input string name, input logic st, input logic dn,
                               input logic er, input logic bz, input logic rd);
        checkOutput({name, "_start"}, 32'(start_o), 32'(st));
        checkOutput({name, "_done"},  32'(done_o),  32'(dn));
        checkOutput({name, "_err"},   32'(err_o),   32'(er));
        checkOutput({name, "_busy"},  32'(busy_o),  32'(bz));
        checkOutput({name, "_ready"}, 32'(bus.byte_ready_o), 32'(rd));
    endtask

    task automatic expectWrite(input logic [31:0] addr, input logic [31:0] data);
        wr_t w;
        w.addr = addr;
        w.data = data;
        exp_q.push_back(w);
    endtask

    task automatic loadReq();
        @(negedge clk);
        load_req_i = 1'b1;
        @(posedge clk);
        #1;
        load_req_i = 1'b0;
    endtask

    // Streams a frame back-to-back with valid held high. Every byte must find
    // ready=1; the 4th byte of each of the first nwords words schedules the
    // cycle at which its write pulse must appear. Returns at the negedge one
    // cycle after the last accept.
    task automatic applyStimulus(input string name, input byte_q_t frame, input int nwords);
        for (int i = 0; i < frame.size(); i++) begin
            @(negedge clk);
            bus.byte_valid_i = 1'b1;
            bus.byte_data_i  = frame[i];
            checkOutput($sformatf("%s_ready_b%0d", name, i), 32'(bus.byte_ready_o), 32'd1);
            if (i >= 2 && i < 2 + 4 * nwords && ((i - 2) % 4) == 3) lat_q.push_back(cyc + 1);
            @(posedge clk);
        end
        @(negedge clk);
        bus.byte_valid_i = 1'b0;
        bus.byte_data_i  = 8'h00;
    endtask

    // Monitor: every write pulse must match the next expected write
    always @(negedge clk) begin
        if (rst_i && bus.imem_we_o) begin
            if (exp_q.size() == 0) begin
                checkOutput("unexpected_write_addr", bus.imem_waddr_o, 32'hFFFF_FFFF);
            end else begin
                wr_t w;
                w = exp_q.pop_front();
                checkOutput("write_addr", bus.imem_waddr_o, w.addr);
                checkOutput("write_data", bus.imem_wdata_o, w.data);
                if (lat_q.size() != 0) checkOutput("write_cycle", 32'(cyc), 32'(lat_q.pop_front()));
                else checkOutput("write_cycle_unscheduled", 32'(cyc), 32'hFFFF_FFFF);
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bus.byte_valid_i = 1'b0;
        bus.byte_data_i  = 8'h00;
        repeat (2) @(negedge clk);
        checkStatus("reset", 0, 0, 0, 0, 0);
        checkOutput("reset_we", 32'(bus.imem_we_o), 32'd0);
        rst_i = 1'b1;
        @(negedge clk);
        checkStatus("idle", 0, 0, 0, 0, 0);

        // N=1, bad checksum
        $display("[TB] frame N=1 with wrong checksum");
        loadReq();
        checkStatus("t1_load", 0, 0, 0, 1, 1);
        expectWrite(32'h0, 32'h00A00513);
        f = {8'h01, 8'h00, 8'h13, 8'h05, 8'hA0, 8'h00, 8'hB6};
        applyStimulus("t1", f, 1);
        checkStatus("t1_end", 0, 0, 1, 0, 0);

        // N=1, good checksum, loaded from ERR
        $display("[TB] frame N=1 with good checksum");
        loadReq();
        checkStatus("t2_load", 0, 0, 0, 1, 1);
        expectWrite(32'h0, 32'h00A00513);
        f = {8'h01, 8'h00, 8'h13, 8'h05, 8'hA0, 8'h00, 8'hB7};
        applyStimulus("t2", f, 1);
        checkStatus("t2_end", 1, 1, 0, 0, 0);

        // N=3 back-to-back, loaded from DONE
        $display("[TB] frame N=3 back-to-back");
        loadReq();
        checkStatus("t3_load", 0, 0, 0, 1, 1);
        expectWrite(32'h0, 32'h11223344);
        expectWrite(32'h4, 32'hDEADBEEF);
        expectWrite(32'h8, 32'h00000001);
        f = {8'h03, 8'h00, 8'h44, 8'h33, 8'h22, 8'h11, 8'hEF, 8'hBE, 8'hAD, 8'hDE,
             8'h01, 8'h00, 8'h00, 8'h00, 8'h64};
        applyStimulus("t3", f, 3);
        checkStatus("t3_end", 1, 1, 0, 0, 0);

        // N=257 exceeds DEPTH; a stray valid byte afterwards is ignored
        $display("[TB] oversize frame");
        loadReq();
        f = {8'h01, 8'h01};
        applyStimulus("t4", f, 0);
        checkStatus("t4_end", 0, 0, 1, 0, 0);
        bus.byte_valid_i = 1'b1;
        bus.byte_data_i  = 8'h55;
        @(negedge clk);
        bus.byte_valid_i = 1'b0;
        checkStatus("t4_stray", 0, 0, 1, 0, 0);

        // N=0, checksum of 00 00
        $display("[TB] empty frame");
        loadReq();
        f = {8'h00, 8'h00, 8'h00};
        applyStimulus("t5", f, 0);
        checkStatus("t5_end", 1, 1, 0, 0, 0);

        // Reset in the middle of the first data word, then a clean reload
        $display("[TB] reset mid-session");
        loadReq();
        f = {8'h01, 8'h00, 8'h13, 8'h05};
        applyStimulus("t6a", f, 0);
        checkOutput("t6_busy_before_reset", 32'(busy_o), 32'd1);
        rst_i = 1'b0;
        #1;
        checkStatus("t6_reset", 0, 0, 0, 0, 0);
        checkOutput("t6_reset_we",    32'(bus.imem_we_o), 32'd0);
        checkOutput("t6_reset_waddr", bus.imem_waddr_o,   32'd0);
        checkOutput("t6_reset_wdata", bus.imem_wdata_o,   32'd0);
        @(negedge clk);
        rst_i = 1'b1;
        @(negedge clk);
        checkStatus("t6_idle", 0, 0, 0, 0, 0);
        loadReq();
        expectWrite(32'h0, 32'h12345678);
        f = {8'h01, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'h09};
        applyStimulus("t6b", f, 1);
        checkStatus("t6_end", 1, 1, 0, 0, 0);

        repeat (3) @(negedge clk);
        checkOutput("pending_writes", 32'(exp_q.size()), 32'd0);
        checkOutput("pending_latencies", 32'(lat_q.size()), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
